// File: rtl/kbd_pkg.sv
// Shared types and constants for the 4x4 PMOD keypad scanner.
// Key codes are {row[1:0], col[1:0]}, which is also the matrix bit index.
package kbd_pkg;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        JAMMED
    } press_state_t;

    // PmodKYPD legend for each code (row-major from the top-left key).
    localparam key_code_t KEY_LABEL [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    function automatic logic [4:0] key_count(input logic [15:0] m);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0, m[i]};
        end
        return n;
    endfunction

    function automatic key_code_t key_index(input logic [15:0] m);
        key_code_t k;
        k = '0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                k = key_code_t'(i);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event handshake between the keypad scanner and its consumer.
// The scanner is the master; the calculator logic is the slave.
interface keypad_scanner_if;
    import kbd_pkg::*;

    logic      KEY_VALID;
    logic      KEY_READY;
    key_code_t KEY_CODE;
    logic      KEY_OVERFLOW;

    modport master (
        output KEY_VALID,
        output KEY_CODE,
        output KEY_OVERFLOW,
        input  KEY_READY
    );

    modport slave (
        input  KEY_VALID,
        input  KEY_CODE,
        input  KEY_OVERFLOW,
        output KEY_READY
    );

endinterface

// File: rtl/keypad_debounce.sv
// Whole-matrix debouncer: accepts a snapshot only after it has been
// seen on DEBOUNCE_SCANS consecutive full scans.
module keypad_debounce #(
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        snap_valid_i,
    input  logic [15:0] snap_i,
    output logic [15:0] matrix_o,
    output logic        changed_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [15:0]   prev_q, prev_d;
    logic [15:0]   mat_q, mat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          chg_q, chg_d;

    // Stable-count update and debounced load on each committed snapshot
    always_comb begin
        prev_d = prev_q;
        mat_d  = mat_q;
        cnt_d  = cnt_q;
        chg_d  = 1'b0;
        if (snap_valid_i) begin
            prev_d = snap_i;
            if (snap_i == prev_q) begin
                if (cnt_q != CW'(DEBOUNCE_SCANS)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = CW'(1);
            end
            if (cnt_d == CW'(DEBOUNCE_SCANS)) begin
                mat_d = snap_i;
                chg_d = (snap_i != mat_q);
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
            mat_q  <= '0;
            cnt_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            mat_q  <= mat_d;
            cnt_q  <= cnt_d;
            chg_q  <= chg_d;
        end
    end

    assign matrix_o  = mat_q;
    assign changed_o = chg_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad controller with debounce, press FSM and
// a one-deep key-event register behind a valid/ready handshake.
module keypad_scanner
    import kbd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [3:0]              ROWS,
    output logic [3:0]              COLS,
    keypad_scanner_if.master        kbd
);

    localparam int DW = $clog2(SETTLE_CYCLES);

    logic [3:0]    rows_s1_q, rows_s2_q;
    logic [1:0]    col_q;
    logic [DW-1:0] dwell_q;
    logic [15:0]   snap_q, snap_d;
    logic          sample, commit;
    logic [15:0]   matrix;
    logic          changed;

    press_state_t  state_q;
    logic          valid_q;
    key_code_t     code_q;
    logic          ovf_q;
    logic [4:0]    nkeys;
    logic          new_ev, accept;

    assign sample = (dwell_q == DW'(SETTLE_CYCLES - 1));
    assign commit = sample && (col_q == 2'd3);
    assign COLS   = ~(4'b0001 << col_q);

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rows_s1_q <= 4'hF;
            rows_s2_q <= 4'hF;
        end else begin
            rows_s1_q <= ROWS;
            rows_s2_q <= rows_s1_q;
        end
    end

    // Merge the current column's pressed rows into the snapshot
    always_comb begin
        snap_d = snap_q;
        for (int r = 0; r < 4; r++) begin
            snap_d[4*r + int'(col_q)] = ~rows_s2_q[r];
        end
    end

    // Column walk and dwell counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            col_q   <= '0;
            dwell_q <= '0;
            snap_q  <= '0;
        end else if (sample) begin
            col_q   <= col_q + 2'd1;
            dwell_q <= '0;
            snap_q  <= snap_d;
        end else begin
            dwell_q <= dwell_q + 1'b1;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .snap_valid_i(commit),
        .snap_i      (snap_d),
        .matrix_o    (matrix),
        .changed_o   (changed)
    );

    assign nkeys  = key_count(matrix);
    assign accept = valid_q & kbd.KEY_READY;
    assign new_ev = changed && (state_q == IDLE) && (nkeys == 5'd1);

    // Press FSM plus the one-deep event register and overflow flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (changed) begin
                unique case (state_q)
                    IDLE: begin
                        if (nkeys == 5'd1) begin
                            state_q <= PRESSED;
                        end else if (nkeys != 5'd0) begin
                            state_q <= JAMMED;
                        end
                    end
                    PRESSED, JAMMED: begin
                        if (nkeys == 5'd0) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            if (accept) begin
                valid_q <= 1'b0;
            end
            if (new_ev) begin
                if (valid_q && !accept) begin
                    ovf_q <= 1'b1;
                end else begin
                    valid_q <= 1'b1;
                    code_q  <= key_index(matrix);
                end
            end
        end
    end

    assign kbd.KEY_VALID    = valid_q;
    assign kbd.KEY_CODE     = code_q;
    assign kbd.KEY_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Short settle/debounce parameters keep each scenario to a few hundred cycles.
module tb_keypad_scanner;
    import kbd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [15:0] keys;
    int          n_checks = 0;
    int          n_errors = 0;
    int          ev_cnt = 0;
    key_code_t   last_code = '0;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SETTLE_CYCLES (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .ROWS (rows),
        .COLS (cols),
        .kbd  (kif.master)
    );

    always #5 clk = ~clk;

    // Key matrix: a row reads low when a pressed key sits on a driven column
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r + c] && !cols[c]) begin
                    rows[r] = 1'b0;
                end
            end
        end
    end

    // Count completed handshakes
    always @(negedge clk) begin
        if (kif.KEY_VALID && kif.KEY_READY) begin
            ev_cnt    = ev_cnt + 1;
            last_code = kif.KEY_CODE;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ev(input string tag, input int bound);
        int start;
        bit got;
        start = ev_cnt;
        got   = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(posedge clk);
            if (ev_cnt > start) got = 1'b1;
        end
        #1;
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int bound);
        bit got;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (kif.KEY_VALID) got = 1'b1;
        end
        @(posedge clk);
        #1;
        chk(tag, 32'(got), 32'd1);
    endtask

    logic [3:0] exp_cols [4];
    int         vhigh;

    initial begin
        exp_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst = 1'b1;
        keys = '0;
        kif.KEY_READY = 1'b1;
        cycles(3);
        chk("rst_cols", 32'(cols), 32'hE);
        chk("rst_valid", 32'(kif.KEY_VALID), 32'd0);
        chk("rst_code", 32'(kif.KEY_CODE), 32'd0);
        chk("rst_ovf", 32'(kif.KEY_OVERFLOW), 32'd0);
        rst = 1'b0;

        // Idle column walk
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("cols_%0d", k), 32'(cols), 32'(exp_cols[k/4]));
        end
        vhigh = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (kif.KEY_VALID) vhigh++;
        end
        cycles(1);
        chk("idle_novalid", 32'(vhigh), 32'd0);

        // Single press row 2 / col 1
        keys = 16'(1 << 9);
        wait_ev("press_r2c1", 70);
        chk("code_r2c1", 32'(last_code), 32'h9);
        chk("label_r2c1", 32'(KEY_LABEL[last_code]), 32'h8);
        cycles(500);
        chk("no_repeat", 32'(ev_cnt), 32'd1);
        keys = '0;
        cycles(100);
        chk("no_release_ev", 32'(ev_cnt), 32'd1);
        keys = 16'(1 << 9);
        wait_ev("repress", 70);
        chk("repress_code", 32'(last_code), 32'h9);
        keys = '0;
        cycles(100);

        // Bouncing press on row 3 / col 0
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'(1 << 12) : 16'h0;
            cycles(10);
        end
        keys = 16'(1 << 12);
        wait_ev("bounce_ev", 120);
        chk("bounce_code", 32'(last_code), 32'hC);
        cycles(150);
        chk("bounce_once", 32'(ev_cnt), 32'd3);
        keys = '0;
        cycles(100);

        // Two keys together, then a clean press
        keys = 16'h8001;
        cycles(150);
        chk("jam_noev", 32'(ev_cnt), 32'd3);
        chk("jam_novalid", 32'(kif.KEY_VALID), 32'd0);
        keys = '0;
        cycles(100);
        keys = 16'(1 << 6);
        wait_ev("after_jam", 70);
        chk("after_jam_code", 32'(last_code), 32'h6);
        keys = '0;
        cycles(100);

        // Overflow with the consumer stalled
        kif.KEY_READY = 1'b0;
        keys = 16'(1 << 1);
        wait_valid("ovf_first", 70);
        keys = '0;
        cycles(100);
        keys = 16'(1 << 11);
        cycles(100);
        chk("ovf_code", 32'(kif.KEY_CODE), 32'h1);
        chk("ovf_valid", 32'(kif.KEY_VALID), 32'd1);
        chk("ovf_flag", 32'(kif.KEY_OVERFLOW), 32'd1);
        kif.KEY_READY = 1'b1;
        cycles(1);
        kif.KEY_READY = 1'b0;
        @(negedge clk);
        chk("ovf_drain", 32'(kif.KEY_VALID), 32'd0);
        chk("ovf_sticky", 32'(kif.KEY_OVERFLOW), 32'd1);
        chk("ovf_evcnt", 32'(ev_cnt), 32'd5);
        keys = '0;
        cycles(100);

        // Reset mid-debounce with key (1,1) held
        kif.KEY_READY = 1'b1;
        keys = 16'(1 << 5);
        cycles(25);
        chk("mid_noev", 32'(ev_cnt), 32'd5);
        rst = 1'b1;
        cycles(1);
        chk("mid_rst_cols", 32'(cols), 32'hE);
        chk("mid_rst_valid", 32'(kif.KEY_VALID), 32'd0);
        chk("mid_rst_code", 32'(kif.KEY_CODE), 32'd0);
        chk("mid_rst_ovf", 32'(kif.KEY_OVERFLOW), 32'd0);
        rst = 1'b0;
        wait_ev("post_rst_ev", 70);
        chk("post_rst_code", 32'(last_code), 32'h5);
        cycles(150);
        chk("post_rst_once", 32'(ev_cnt), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Column-scanning controller for the 4x4 matrix keypad on PMOD JA. Drives one column low at a time, samples the row lines, debounces whole-matrix snapshots and emits one key-press event per clean single-key press through a valid/ready handshake. It sits between the JA pins (COLS on JA[4:1], ROWS on JA[10:7]) and the calculator input logic, in the CLK domain.

## Interface
- SETTLE_CYCLES, 1000: CLK cycles each column is driven before rows are sampled (10 us at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 20: consecutive identical full-matrix snapshots required to accept a new debounced state; minimum 1.
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  synchronous, active-high reset.
- ROWS  in  4  raw row lines, pulled up externally, active-low, asynchronous.
- COLS  out  4  column drive, one-hot active-low.
- KEY_VALID  out  1  event pending.
- KEY_READY  in  1  consumer accepts event.
- KEY_CODE  out  4  {row[1:0], col[1:0]} of pressed key; stable while KEY_VALID.
- KEY_OVERFLOW  out  1  sticky: a press was dropped because an event was still pending; cleared only by RESET.

## Operation
- ROWS passes through a 2-flop synchronizer before any use.
- Scan: column index c (2 bits) and dwell counter d. COLS = ~(1 << c). d counts 0..SETTLE_CYCLES-1; at d = SETTLE_CYCLES-1 the synchronized, inverted rows are written into snapshot bits [4r+c], then c increments mod 4 and d returns to 0.
- Snapshot commit: at the sample cycle of c = 3 the 16-bit snapshot is complete. If it equals the previous snapshot, stable count increments (saturating at DEBOUNCE_SCANS); otherwise count = 1. When count reaches DEBOUNCE_SCANS, the debounced matrix is loaded from the snapshot.
- Press FSM, evaluated when the debounced matrix changes:
  - IDLE: zero keys. Exactly one key goes to PRESSED and raises an event with that key's code. Two or more keys go to JAMMED with no event.
  - PRESSED: zero keys goes to IDLE. Any other pattern stays in PRESSED, with no new event and no change of code.
  - JAMMED: zero keys goes to IDLE; otherwise stays in JAMMED.
- No auto-repeat. A release is never reported.
- Handshake: the event register is one entry deep. KEY_VALID stays high and KEY_CODE is held until the first cycle with KEY_VALID & KEY_READY, and KEY_VALID clears on the following edge.
- A new event while KEY_VALID=1 and not accepted in that same cycle is dropped, and KEY_OVERFLOW is set. A new event in the cycle a handshake completes is not dropped: it loads, and KEY_VALID stays high.

## Timing
- Reset values:
  - COLS = 4'b1110, c = 0, d = 0.
  - Snapshot, previous snapshot and debounced matrix all 0; stable count 0.
  - FSM in IDLE.
  - KEY_VALID = 0, KEY_CODE = 0, KEY_OVERFLOW = 0.
- One full scan takes 4·SETTLE_CYCLES cycles.
- Event latency from a stable press: 2 cycles (synchronizer), plus up to one partial scan, plus DEBOUNCE_SCANS full scans. KEY_VALID rises 1 cycle after the debounced matrix updates.
- KEY_READY has no combinational path to any output.
- RESET mid-scan or mid-press: everything returns to reset values. A key held across RESET is reported once after the debounce completes (IDLE with one key).

## Structure
- Shared package kbd_pkg holds:
  - key_code_t (4 bits) and the press-FSM enum {IDLE, PRESSED, JAMMED}.
  - Constant KEY_LABEL[16] mapping codes to PmodKYPD legends (0-9, A-F), used by downstream logic and the bench.
- Sub-module keypad_debounce: 16-bit snapshot in, stable counter, debounced matrix out plus a one-cycle "changed" strobe. The scanner, press FSM and handshake register stay in keypad_scanner.

## Test plan
Directed tests use SETTLE_CYCLES=4 and DEBOUNCE_SCANS=3. The bench keypad model drives ROWS from the pressed-key set and COLS.
- Reset release, no keys -> COLS cycles 1110, 1101, 1011, 0111 every 4 cycles; KEY_VALID stays 0 for 200 cycles.
- Hold row 2 / col 1 -> exactly one KEY_VALID with KEY_CODE=4'b1001, within 2+16+48 cycles of press. Holding 500 cycles gives no second event; release then re-press gives a second event.
- Press with 3 bounces (toggle every 10 cycles for 60 cycles), then stable -> exactly one event, code correct.
- Keys (0,0) and (3,3) pressed together -> no event. Release both, then press (1,2) -> one event, code 4'b0110.
- KEY_READY held 0. Press and release (0,1), then press (2,3) -> KEY_CODE stays 4'b0001, KEY_OVERFLOW=1. After KEY_READY=1 for 1 cycle, KEY_VALID=0 next cycle.
- RESET asserted for 1 cycle mid-debounce of key (1,1), key held -> outputs at reset values the next cycle; one event 4'b0101 after a full debounce.
